activity_led_scheduler: RTL and testbench
=========================================

Name: activity_led_scheduler

Overview:
- Shares one board activity LED among NUM_SRC activity sources (e.g. DMA done, inference start, frame done, error).
- Each source latches a pending request. A round-robin arbiter grants the LED to one source at a time.
- The granted source is identified on the LED by a burst of (index+1) blinks, followed by a dark separation gap.
- Sits next to the board LED outputs, driven by single-cycle or level activity strobes from the accelerator top level.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- PHASE_WIDTH, 24, each ON or OFF phase lasts P = 2**PHASE_WIDTH clk cycles; GAP lasts 2P cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- trigger  input  NUM_SRC  per-source activity strobe, level-sampled every cycle.
- led_out  output  1  LED drive, 1 = lit.
- busy  output  1  blink sequence in progress.
- grant_id  output  $clog2(NUM_SRC)  index of the source being displayed.
- pending  output  NUM_SRC  latched requests not yet served.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and takes priority over all other logic.
- Reset values: state = IDLE; led_out = 0; busy = 0; grant_id = 0; pending = 0; blink_cnt = 0; timer = 0; last_grant = NUM_SRC-1, so source 0 has top priority after reset.
- Pending register:
  - pending[i] is set at any edge where trigger[i] = 1.
  - pending[i] is cleared at the edge where source i is granted.
  - If trigger[i] = 1 in the grant cycle, set wins and pending[i] stays 1.
- Arbiter:
  - Combinational over the registered pending vector.
  - Search order is last_grant+1, last_grant+2, … with wrap modulo NUM_SRC. The first set bit wins.
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - If pending != 0: at the next edge, state = ON, grant_id = winner, last_grant = winner, blink_cnt = winner+1, timer = 0, pending[winner] cleared.
  - Otherwise stay in IDLE.
- ON:
  - timer increments each cycle.
  - At timer = P-1: state = OFF, timer = 0, blink_cnt decrements.
- OFF:
  - At timer = P-1: if blink_cnt != 0, state = ON; else state = GAP. timer = 0 in both cases.
- GAP:
  - At timer = 2P-1: state = IDLE, timer = 0.
- Timer width is PHASE_WIDTH+1 bits. Counters never wrap in normal operation.
- Outputs:
  - led_out = 1 exactly while state = ON. It is a registered state decode with no combinational path from trigger.
  - busy = (state != IDLE).
  - grant_id holds its last value in IDLE.
- Latency and sequence length:
  - Trigger sampled at edge t gives pending = 1 after t. If idle, the grant occurs at edge t+1 and led_out = 1 from edge t+1.
  - Busy duration for source k = (k+1)·2P + 2P cycles.
  - At least one IDLE cycle separates consecutive sequences.
- Triggers arriving while busy only set pending. The current sequence is never pre-empted or extended.
- Repeated triggers on an already-pending source are merged: one display per pending bit.
- Reset mid-sequence: at the next edge, all state returns to reset values and in-flight and pending requests are dropped. A trigger coincident with rst is ignored.

Test Plan (NUM_SRC = 4, PHASE_WIDTH = 2, so P = 4, GAP = 8):
1. Hold rst = 1 for 3 cycles with trigger = 4'b1111 -> led_out = 0, busy = 0, pending = 0, grant_id = 0 throughout; after release, first grant is source 0.
2. Single-cycle trigger = 4'b0100 at edge t -> pending[2] = 1 after t; grant at t+1 with grant_id = 2; led_out shows 3 pulses, each 4 cycles high and 4 low, then 8 dark cycles; busy high exactly 32 cycles; pending = 0 at end.
3. trigger = 4'b1001 in one cycle -> source 0 is shown first (1 pulse, busy 16 cycles); after 1 IDLE cycle source 3 is shown (4 pulses, busy 40 cycles).
4. Round-robin check: after serving source 1, pulse trigger = 4'b0011 while busy -> next grant is source 0 (search starts at 2, wraps), then source 1; repeated triggers on source 0 while pending -> still served once.
5. trigger[2] = 1 in the exact cycle source 2 is granted -> pending[2] remains 1 and source 2 is served again after the current sequence plus 1 IDLE cycle.
6. Assert rst for 1 cycle during the second ON pulse of source 2 -> next edge led_out = 0, busy = 0, pending = 0; subsequent trigger = 4'b1100 -> source 2 is granted first, since priority resets to source 0 and 0/1 are not pending.

Source files
------------

// File: rtl/activity_led_scheduler.sv
// activity_led_scheduler: round-robin sharing of one LED, showing the granted source as (index+1) blinks then a dark gap
module activity_led_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         trigger,
    output logic                       led_out,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic [NUM_SRC-1:0]         pending
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int TW = PHASE_WIDTH + 1;
    localparam int CW = $clog2(NUM_SRC + 1);
    localparam logic [TW-1:0] P_END = {1'b0, {PHASE_WIDTH{1'b1}}};
    localparam logic [TW-1:0] G_END = {TW{1'b1}};
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
    state_t r_state;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_blink;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_grant;
    logic [NUM_SRC-1:0] r_pending;
    logic r_led;
    logic r_busy;
    logic w_found;
    logic [IW-1:0] w_winner;
    logic [NUM_SRC-1:0] w_clear;
    logic w_p_done;
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (r_pending[(int'(r_last) + k) % NUM_SRC]) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_last) + k) % NUM_SRC);
            end
        end
        w_clear  = (r_state == IDLE && w_found) ? (NUM_SRC'(1) << w_winner) : '0;
        w_p_done = (r_timer == P_END);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_blink   <= '0;
            r_last    <= IW'(NUM_SRC - 1);
            r_grant   <= '0;
            r_pending <= '0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | trigger;
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= ON;
                        r_led   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_blink <= CW'(w_winner) + CW'(1);
                        r_timer <= '0;
                    end
                end
                ON: begin
                    if (w_p_done) begin
                        r_state <= OFF;
                        r_led   <= 1'b0;
                        r_timer <= '0;
                        r_blink <= r_blink - CW'(1);
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                OFF: begin
                    if (w_p_done) begin
                        r_state <= (r_blink != '0) ? ON : GAP;
                        r_led   <= (r_blink != '0);
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                GAP: begin
                    if (r_timer == G_END) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign led_out  = r_led;
    assign busy     = r_busy;
    assign grant_id = r_grant;
    assign pending  = r_pending;
endmodule

// File: tb/tb_activity_led_scheduler.sv
// tb_activity_led_scheduler: scoreboard bench, expected grant order queued at stimulus time and checked per blink sequence
module tb_activity_led_scheduler;
    localparam int P = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] trigger = 4'b0;
    logic led_out;
    logic busy;
    logic [1:0] grant_id;
    logic [3:0] pending;
    int total = 0;
    int bad = 0;
    int exp_q[$];
    always #5 clk = ~clk;
    activity_led_scheduler #(.NUM_SRC(4), .PHASE_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .led_out(led_out),
        .busy(busy), .grant_id(grant_id), .pending(pending)
    );
    task automatic measure(input int trig_at, input logic [3:0] trig_val, input int trig_len, input int rst_at,
                           output int gid, output int wait_n, output int len, output int pulses, output int pat_err);
        logic prev;
        int k;
        gid = -1; wait_n = 0; len = 0; pulses = 0; pat_err = 0; prev = 1'b0;
        while (!busy && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        if (!busy) return;
        gid = int'(grant_id);
        k = gid;
        while (busy && len < 300) begin
            if (led_out !== ((len < (k + 1) * 2 * P) && (len % (2 * P) < P))) pat_err++;
            if (led_out && !prev) pulses++;
            prev = led_out;
            trigger = (len >= trig_at && len < trig_at + trig_len) ? trig_val : 4'b0;
            rst = (len == rst_at);
            @(negedge clk);
            len++;
        end
        trigger = 4'b0;
        rst = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        int gid, w, len, pul, pe, e;
        rst = 1'b1;
        trigger = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({led_out, busy, grant_id, pending} !== 8'h00) begin
                bad++;
                $display("FAIL reset_state: got %b want 00000000", {led_out, busy, grant_id, pending});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        total++;
        if (pending !== 4'b1111 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_pending: got %b busy %b want 1111 busy 0", pending, busy);
        end
        for (int i = 0; i < 4; i++) begin
            measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
            e = exp_q.pop_front();
            total++;
            if (gid !== e) begin bad++; $display("FAIL reset_order_grant: got %0d want %0d", gid, e); end
            total++;
            if (len !== (e + 2) * 2 * P) begin bad++; $display("FAIL reset_order_busy: got %0d want %0d", len, (e + 2) * 2 * P); end
            total++;
            if (pul !== e + 1 || pe !== 0) begin bad++; $display("FAIL reset_order_blinks: got %0d pulses %0d errs want %0d pulses 0 errs", pul, pe, e + 1); end
            total++;
            if (w !== 1) begin bad++; $display("FAIL reset_order_latency: got %0d want 1", w); end
        end
    endtask
    task automatic test_single();
        int gid, w, len, pul, pe, e;
        trigger = 4'b0100;
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(2);
        total++;
        if (pending !== 4'b0100 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_pending: got %b busy %b want 0100 busy 0", pending, busy);
        end
        measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
        e = exp_q.pop_front();
        total++;
        if (gid !== e) begin bad++; $display("FAIL single_grant: got %0d want %0d", gid, e); end
        total++;
        if (w !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", w); end
        total++;
        if (len !== 32) begin bad++; $display("FAIL single_busy: got %0d want 32", len); end
        total++;
        if (pul !== 3 || pe !== 0) begin bad++; $display("FAIL single_blinks: got %0d pulses %0d errs want 3 pulses 0 errs", pul, pe); end
        total++;
        if (pending !== 4'b0) begin bad++; $display("FAIL single_pending_end: got %b want 0000", pending); end
    endtask
    task automatic test_two_sources();
        int gid, w, len, pul, pe, e;
        do_reset();
        trigger = 4'b1001;
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(0); exp_q.push_back(3);
        for (int i = 0; i < 2; i++) begin
            measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
            e = exp_q.pop_front();
            total++;
            if (gid !== e) begin bad++; $display("FAIL two_grant: got %0d want %0d", gid, e); end
            total++;
            if (len !== (e == 0 ? 16 : 40)) begin bad++; $display("FAIL two_busy: got %0d want %0d", len, (e == 0 ? 16 : 40)); end
            total++;
            if (pul !== e + 1 || pe !== 0) begin bad++; $display("FAIL two_blinks: got %0d pulses %0d errs want %0d pulses 0 errs", pul, pe, e + 1); end
            total++;
            if (w !== 1) begin bad++; $display("FAIL two_idle_gap: got %0d want 1", w); end
        end
    endtask
    task automatic test_round_robin();
        int gid, w, len, pul, pe, e;
        do_reset();
        trigger = 4'b0010;
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(1);
        measure(2, 4'b0011, 3, -1, gid, w, len, pul, pe);
        e = exp_q.pop_front();
        exp_q.push_back(0); exp_q.push_back(1);
        total++;
        if (gid !== e || len !== 24) begin bad++; $display("FAIL rr_first: got id %0d len %0d want id %0d len 24", gid, len, e); end
        total++;
        if (pending !== 4'b0011) begin bad++; $display("FAIL rr_merged_pending: got %b want 0011", pending); end
        for (int i = 0; i < 2; i++) begin
            measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
            e = exp_q.pop_front();
            total++;
            if (gid !== e) begin bad++; $display("FAIL rr_grant: got %0d want %0d", gid, e); end
            total++;
            if (len !== (e + 2) * 2 * P || pul !== e + 1 || pe !== 0) begin
                bad++;
                $display("FAIL rr_sequence: got len %0d pulses %0d errs %0d want len %0d pulses %0d errs 0", len, pul, pe, (e + 2) * 2 * P, e + 1);
            end
        end
        w = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) w++;
        end
        total++;
        if (w !== 0 || pending !== 4'b0) begin bad++; $display("FAIL rr_served_once: got %0d busy cycles pending %b want 0 busy cycles pending 0000", w, pending); end
    endtask
    task automatic test_set_wins();
        int gid, w, len, pul, pe, e;
        trigger = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(2); exp_q.push_back(2);
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || pending !== 4'b0100) begin
            bad++;
            $display("FAIL setwin_grant_cycle: got busy %b id %0d pending %b want busy 1 id 2 pending 0100", busy, grant_id, pending);
        end
        for (int i = 0; i < 2; i++) begin
            measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
            e = exp_q.pop_front();
            total++;
            if (gid !== e || len !== 32 || pul !== 3 || pe !== 0) begin
                bad++;
                $display("FAIL setwin_sequence: got id %0d len %0d pulses %0d errs %0d want id %0d len 32 pulses 3 errs 0", gid, len, pul, pe, e);
            end
            total++;
            if (w !== (i == 0 ? 0 : 1)) begin bad++; $display("FAIL setwin_idle_gap: got %0d want %0d", w, (i == 0 ? 0 : 1)); end
        end
    endtask
    task automatic test_reset_mid();
        int gid, w, len, pul, pe, e;
        do_reset();
        trigger = 4'b0100;
        @(negedge clk);
        trigger = 4'b0;
        measure(3, 4'b0001, 1, 9, gid, w, len, pul, pe);
        total++;
        if (gid !== 2 || len !== 10 || pul !== 2) begin
            bad++;
            $display("FAIL midrst_truncated: got id %0d len %0d pulses %0d want id 2 len 10 pulses 2", gid, len, pul);
        end
        total++;
        if ({led_out, busy, grant_id, pending} !== 8'h00) begin
            bad++;
            $display("FAIL midrst_cleared: got %b want 00000000", {led_out, busy, grant_id, pending});
        end
        trigger = 4'b1100;
        @(negedge clk);
        trigger = 4'b0;
        exp_q.push_back(2); exp_q.push_back(3);
        for (int i = 0; i < 2; i++) begin
            measure(-1, 4'b0, 0, -1, gid, w, len, pul, pe);
            e = exp_q.pop_front();
            total++;
            if (gid !== e) begin bad++; $display("FAIL midrst_grant: got %0d want %0d", gid, e); end
            total++;
            if (len !== (e + 2) * 2 * P || pul !== e + 1 || pe !== 0) begin
                bad++;
                $display("FAIL midrst_sequence: got len %0d pulses %0d errs %0d want len %0d pulses %0d errs 0", len, pul, pe, (e + 2) * 2 * P, e + 1);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_two_sources();
        test_round_robin();
        test_set_wins();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
